// File: rtl/two_out_of_five_pkg.sv
// Shared definitions for the 2-out-of-5 serial transmitter: state encoding,
// the 7-4-2-1-0 codeword table and frame constants.
package two_out_of_five_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int NUM_BITS  = 5;
   localparam int MAX_DIGIT = 9;

   // Index n holds the codeword for digit n, bit 4 = a (weight 7), bit 0 = e (weight 0).
   localparam logic [9:0][4:0] ENC_TABLE = {
      5'b10100,  // 9
      5'b10010,  // 8
      5'b10001,  // 7
      5'b01100,  // 6
      5'b01010,  // 5
      5'b01001,  // 4
      5'b00110,  // 3
      5'b00101,  // 2
      5'b00011,  // 1
      5'b11000   // 0
   };

   // Out-of-range digits map to all zeros so they can never look like a legal codeword.
   function automatic logic [4:0] encode_digit(input logic [3:0] digit);
      logic [4:0] code;
      code = 5'b00000;
      case (digit)
         4'd0:    code = ENC_TABLE[0];
         4'd1:    code = ENC_TABLE[1];
         4'd2:    code = ENC_TABLE[2];
         4'd3:    code = ENC_TABLE[3];
         4'd4:    code = ENC_TABLE[4];
         4'd5:    code = ENC_TABLE[5];
         4'd6:    code = ENC_TABLE[6];
         4'd7:    code = ENC_TABLE[7];
         4'd8:    code = ENC_TABLE[8];
         4'd9:    code = ENC_TABLE[9];
         default: code = 5'b00000;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/two_out_of_five_enc.sv
// Combinational BCD to 2-out-of-5 encoder; flags digits above 9 as invalid.
module two_out_of_five_enc
   import two_out_of_five_pkg::*;
(
   input  logic [3:0] digit,
   output logic [4:0] code,
   output logic       invalid
);

   always_comb begin
      invalid = (digit > 4'(MAX_DIGIT));
      code    = encode_digit(digit);
   end

endmodule

// File: rtl/two_out_of_five_tx.sv
// 2-out-of-5 serial transmitter: start bit, five code bits MSB first, stop bit,
// each BIT_CYCLES clocks long. Every output is registered.
module two_out_of_five_tx
   import two_out_of_five_pkg::*;
#(
   parameter int BIT_CYCLES = 4
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] digit,
   output logic       sout,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d,
   output logic       e,
   output logic       busy,
   output logic       done,
   output logic       err,
   output tx_state_t  dbg_state
);

   localparam logic [7:0] LAST_CNT = 8'(BIT_CYCLES - 1);
   localparam logic [2:0] LAST_IDX = 3'(NUM_BITS - 1);

   // Handshake: start is a one-cycle request, honoured only in IDLE or in the
   // done cycle of a frame; any other start strobe is dropped silently.

   tx_state_t  state, state_n;
   logic [7:0] cnt, cnt_n;
   logic [2:0] idx, idx_n;
   logic [4:0] code_q, code_n;
   logic       sout_n, busy_n, done_n, err_n;
   logic       load, reject, bit_end;
   logic [4:0] enc_code;
   logic       enc_invalid;

   two_out_of_five_enc u_enc (
      .digit   (digit),
      .code    (enc_code),
      .invalid (enc_invalid)
   );

   assign bit_end = (cnt == LAST_CNT);

   // State register, including the output flops fed from the output process.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= 8'd0;
         idx    <= 3'd0;
         code_q <= 5'b00000;
         sout   <= 1'b1;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         idx    <= idx_n;
         code_q <= code_n;
         sout   <= sout_n;
         busy   <= busy_n;
         done   <= done_n;
         err    <= err_n;
      end
   end

   // Next-state logic. The last STOP cycle behaves like IDLE for start so
   // back-to-back frames run with no idle gap.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      load    = 1'b0;
      reject  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (enc_invalid) begin
                  reject = 1'b1;
               end else begin
                  load    = 1'b1;
                  state_n = START;
                  cnt_n   = 8'd0;
               end
            end
         end
         START: begin
            if (bit_end) begin
               state_n = DATA;
               cnt_n   = 8'd0;
               idx_n   = 3'd0;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_n = 8'd0;
               if (idx == LAST_IDX) begin
                  state_n = STOP;
               end else begin
                  idx_n = idx + 3'd1;
               end
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_n   = 8'd0;
               state_n = IDLE;
               if (start) begin
                  if (enc_invalid) begin
                     reject = 1'b1;
                  end else begin
                     load    = 1'b1;
                     state_n = START;
                  end
               end
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = 8'd0;
            idx_n   = 3'd0;
         end
      endcase
   end

   // Output logic: computes what each output flop will hold in the next cycle.
   always_comb begin
      code_n = load ? enc_code : code_q;
      sout_n = 1'b1;
      case (state_n)
         START:   sout_n = 1'b0;
         DATA:    sout_n = code_n[LAST_IDX - idx_n];
         default: sout_n = 1'b1;
      endcase
      busy_n = (state_n != IDLE);
      done_n = (state_n == STOP) && (cnt_n == LAST_CNT);
      err_n  = reject;
   end

   assign {a, b, c, d, e} = code_q;
   assign dbg_state       = state;

endmodule

// File: tb/tb_two_out_of_five_tx.sv
// Directed bench for two_out_of_five_tx: one instance at BIT_CYCLES=4 and one at
// BIT_CYCLES=1, checked against hand-written codewords and frame timing.
module tb_two_out_of_five_tx;

   typedef struct {
      logic [3:0] digit;
      logic [4:0] code;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       sel;          // 0 = BIT_CYCLES 4 instance, 1 = BIT_CYCLES 1 instance
   logic       drv_start;
   logic [3:0] drv_digit;

   logic       start4, start1;
   logic       sout4, a4, b4, c4, d4, e4, busy4, done4, err4;
   logic       sout1, a1, b1, c1, d1, e1, busy1, done1, err1;
   logic [1:0] st4, st1;

   logic       mon_sout, mon_busy, mon_done, mon_err;
   logic [4:0] mon_code;
   logic [1:0] mon_state;

   int checks;
   int errors;
   vec_t vecs[10];

   assign start4 = drv_start & ~sel;
   assign start1 = drv_start & sel;

   assign mon_sout  = sel ? sout1 : sout4;
   assign mon_busy  = sel ? busy1 : busy4;
   assign mon_done  = sel ? done1 : done4;
   assign mon_err   = sel ? err1  : err4;
   assign mon_code  = sel ? {a1, b1, c1, d1, e1} : {a4, b4, c4, d4, e4};
   assign mon_state = sel ? st1 : st4;

   two_out_of_five_tx #(.BIT_CYCLES(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .digit(drv_digit),
      .sout(sout4), .a(a4), .b(b4), .c(c4), .d(d4), .e(e4),
      .busy(busy4), .done(done4), .err(err4), .dbg_state(st4)
   );

   two_out_of_five_tx #(.BIT_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .digit(drv_digit),
      .sout(sout1), .a(a1), .b(b1), .c(c1), .d(d1), .e(e1),
      .busy(busy1), .done(done1), .err(err1), .dbg_state(st1)
   );

   // Clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [8:0] snap();
      return {mon_sout, mon_busy, mon_done, mon_err, mon_code};
   endfunction

   // Driver: one-cycle start strobe; returns in cycle 1 after the accept edge.
   task automatic launch(input logic [3:0] dg);
      drv_start = 1'b1;
      drv_digit = dg;
      @(negedge clk);
      drv_start = 1'b0;
   endtask

   // Follows a whole frame from cycle 1, optionally injecting a start strobe mid-frame
   // or chaining a new start in the done cycle.
   task automatic watch_frame(input int bc, input logic [4:0] exp, input int inj_cycle,
                              input logic [3:0] inj_digit, input bit chain,
                              input logic [3:0] chain_digit);
      int total;
      total = 7 * bc;
      for (int cyc = 1; cyc <= total; cyc++) begin
         logic es;
         int   j;
         if (cyc <= bc) begin
            es = 1'b0;
         end else if (cyc <= 6 * bc) begin
            j  = (cyc - 1 - bc) / bc;
            es = exp[4 - j];
         end else begin
            es = 1'b1;
         end
         chk($sformatf("frame bc%0d code%b cyc%0d {sout,busy,done,err,abcde}", bc, exp, cyc),
             16'(snap()), 16'({es, 1'b1, (cyc == total), 1'b0, exp}));
         if (cyc == inj_cycle) begin
            drv_start = 1'b1;
            drv_digit = inj_digit;
         end else if (chain && cyc == total) begin
            drv_start = 1'b1;
            drv_digit = chain_digit;
         end else begin
            drv_start = 1'b0;
         end
         @(negedge clk);
      end
      drv_start = 1'b0;
   endtask

   task automatic check_idle(input string name, input logic [4:0] exp);
      chk({name, " idle outputs"}, 16'(snap()), 16'({1'b1, 1'b0, 1'b0, 1'b0, exp}));
      chk({name, " idle state"}, 16'(mon_state), 16'd0);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      sel       = 1'b0;
      drv_start = 1'b0;
      drv_digit = 4'd0;

      vecs[0] = '{4'd0, 5'b11000};
      vecs[1] = '{4'd1, 5'b00011};
      vecs[2] = '{4'd2, 5'b00101};
      vecs[3] = '{4'd3, 5'b00110};
      vecs[4] = '{4'd4, 5'b01001};
      vecs[5] = '{4'd5, 5'b01010};
      vecs[6] = '{4'd6, 5'b01100};
      vecs[7] = '{4'd7, 5'b10001};
      vecs[8] = '{4'd8, 5'b10010};
      vecs[9] = '{4'd9, 5'b10100};

      repeat (2) @(negedge clk);
      sel = 1'b0;
      check_idle("reset bc4", 5'b00000);
      sel = 1'b1;
      check_idle("reset bc1", 5'b00000);
      rst = 1'b0;
      sel = 1'b0;
      repeat (2) @(negedge clk);
      check_idle("after reset bc4", 5'b00000);

      // digit 3, BIT_CYCLES 4: 28-cycle frame with done in cycle 28
      launch(4'd3);
      watch_frame(4, 5'b00110, 0, 4'd0, 1'b0, 4'd0);
      check_idle("after digit3", 5'b00110);

      // illegal digit: err only, codeword and line untouched
      launch(4'd12);
      chk("digit12 cycle1", 16'(snap()), 16'({1'b1, 1'b0, 1'b0, 1'b1, 5'b00110}));
      @(negedge clk);
      chk("digit12 cycle2", 16'(snap()), 16'({1'b1, 1'b0, 1'b0, 1'b0, 5'b00110}));
      chk("digit12 state", 16'(mon_state), 16'd0);

      // start while busy is ignored
      launch(4'd9);
      watch_frame(4, 5'b10100, 5, 4'd2, 1'b0, 4'd0);
      check_idle("after ignored start", 5'b10100);

      // back-to-back: digit 0 requested in the done cycle of a digit 1 frame
      launch(4'd1);
      watch_frame(4, 5'b00011, 0, 4'd0, 1'b1, 4'd0);
      watch_frame(4, 5'b11000, 0, 4'd0, 1'b0, 4'd0);
      check_idle("after back-to-back", 5'b11000);

      // table sweep at BIT_CYCLES 1
      sel = 1'b1;
      for (int i = 0; i < 10; i++) begin
         launch(vecs[i].digit);
         watch_frame(1, vecs[i].code, 0, 4'd0, 1'b0, 4'd0);
         check_idle($sformatf("sweep digit%0d", i), vecs[i].code);
         chk($sformatf("sweep digit%0d ones", i), 16'($countones(mon_code)), 16'd2);
      end

      // reset mid-DATA at cycle 10 of a digit 7 frame
      sel = 1'b0;
      launch(4'd7);
      repeat (9) @(negedge clk);
      chk("rst pre cycle10", 16'(snap()), 16'({1'b0, 1'b1, 1'b0, 1'b0, 5'b10001}));
      rst = 1'b1;
      #1;
      chk("rst same cycle", 16'(snap()), 16'({1'b1, 1'b0, 1'b0, 1'b0, 5'b00000}));
      chk("rst same cycle state", 16'(mon_state), 16'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         chk($sformatf("post rst cyc%0d", k), 16'(snap()), 16'({1'b1, 1'b0, 1'b0, 1'b0, 5'b00000}));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
